fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared constants for the shared-FIFO write arbiter:
//   - FSM state encoding (IDLE = 0, BUSY = 1)
//   - default requester count, data width and burst length
//   - width of the grant index / last-owner fields
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  localparam int NREQ_DEF  = 4;   // write requesters (2..8)
  localparam int DW_DEF    = 8;   // data width of the shared FIFO
  localparam int BURST_DEF = 4;   // maximum beats per grant (1..15)

  localparam int GID_W     = 3;   // grant index width, covers up to 8 requesters

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. The search starts at last_owner+1 and
// wraps modulo NREQ, so the previous owner has the lowest priority.
// Ports:
//   req_valid  [NREQ-1:0]  request vector
//   last_owner [2:0]       index of the most recent owner
//   winner     [2:0]       index of the selected requester (0 if none)
//   any_valid              at least one request is present
// ---------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [GID_W-1:0] last_owner,
  output logic [GID_W-1:0] winner,
  output logic             any_valid
);

  // NOTE: every variable written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    // Offset k walks the priority ring; the first hit stops further updates.
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!any_valid && req_valid[j] && (j == (int'(last_owner) + k) % NREQ)) begin
          winner    = GID_W'(j);
          any_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter granting NREQ write requesters bursts of up to BURST
// beats into one shared FIFO. Arbitration takes one IDLE cycle; the owner
// then streams beats while fifo_full is low. The grant ends on the BURST-th
// beat or as soon as the owner drops its valid.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   req_valid      [NREQ]     per-requester write request
//   req_data       [NREQ*DW]  per-requester data, requester i at [i*DW +: DW]
//   req_ready      [NREQ]     per-requester accept (one-hot or zero)
//   fifo_full      shared FIFO full flag
//   fifo_write_en  shared FIFO write strobe (combinational beat)
//   fifo_data_in   [DW]       shared FIFO write data (zero when idle)
//   grant_id       [3]        current owner, meaningful while busy
//   busy           high in BUSY state
//   grant_cnt      [NREQ*8]   per-requester saturating grant counters
//
// Build option: define FIFO_ARB_GRANT_CNT_EN to enable the grant counters;
// otherwise grant_cnt is tied to zero.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_write_en,
  output logic [DW-1:0]        fifo_data_in,
  output logic [GID_W-1:0]     grant_id,
  output logic                 busy,
  output logic [NREQ*8-1:0]    grant_cnt
);

  logic [0:0]       state;
  logic [3:0]       beat_cnt;
  logic [GID_W-1:0] last_owner;
  logic [GID_W-1:0] winner;
  logic             any_valid;
  logic             owner_valid;
  logic             beat;
  logic             last_beat;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_valid  (req_valid),
    .last_owner (last_owner),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  // Owner mux: everything is gated by BUSY, so IDLE (and reset) force the
  // ready, strobe and data outputs to zero without extra logic.
  always_comb begin
    owner_valid  = 1'b0;
    fifo_data_in = '0;
    req_ready    = '0;
    if (state == ST_BUSY) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_id == GID_W'(i)) begin
          owner_valid  = req_valid[i];
          fifo_data_in = req_data[i*DW +: DW];
          req_ready[i] = !fifo_full;
        end
      end
    end
  end

  assign beat          = owner_valid && !fifo_full;
  assign last_beat     = beat && (beat_cnt == 4'(BURST - 1));
  assign fifo_write_en = beat;
  assign busy          = (state == ST_BUSY);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_owner <= GID_W'(NREQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant_id <= winner;
            beat_cnt <= '0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A stalled cycle (fifo_full) neither counts nor ends the grant.
          if (!owner_valid || last_beat) begin
            state      <= ST_IDLE;
            last_owner <= grant_id;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_GRANT_CNT_EN
  logic [7:0] cnt_q [NREQ];
  logic       grant_start;

  assign grant_start = (state == ST_IDLE) && any_valid;

  // NOTE: the counter array is small and architecturally visible, so it is
  // reset like any other register rather than treated as an uninitialised RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_start && (winner == GID_W'(i)) && (cnt_q[i] != 8'hFF)) begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign grant_cnt[g*8 +: 8] = cnt_q[g];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule
